// File: rtl/wb_regfile.sv
// Writeback-stage register file: selects the WB value, writes a 32x32 array and serves two
// bypassed decode read ports plus an unbypassed debug read port.
module wb_regfile (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        RegWrite_WB,
    input  logic        MemToReg_WB,
    input  logic        jal_WB,
    input  logic [4:0]  RegDst1Result_WB,
    input  logic [31:0] ReadData_WB,
    input  logic [31:0] ALUResult_WB,
    input  logic [31:0] PCPlus8_WB,
    input  logic [4:0]  ReadReg1,
    input  logic [4:0]  ReadReg2,
    input  logic [4:0]  DbgReg,
    output logic [31:0] ReadData1,
    output logic [31:0] ReadData2,
    output logic [31:0] DbgData,
    output logic [31:0] WriteData_WB,
    output logic        WriteEn_WB,
    output logic [4:0]  WriteAddr_WB
);

    logic [31:0] regs_q [32];

    always_comb begin
        WriteData_WB = ALUResult_WB;
        if (jal_WB) begin
            WriteData_WB = PCPlus8_WB;
        end else if (MemToReg_WB) begin
            WriteData_WB = ReadData_WB;
        end
        WriteAddr_WB = jal_WB ? 5'd31 : RegDst1Result_WB;
        WriteEn_WB   = (RegWrite_WB | jal_WB) & (WriteAddr_WB != 5'd0) & ~Reset;
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            for (int i = 0; i < 32; i++) begin
                regs_q[i] <= 32'h0;
            end
        end else if (WriteEn_WB) begin
            regs_q[WriteAddr_WB] <= WriteData_WB;
        end
    end

    // Decode ports see the in-flight WB write; address 0 is hard-wired to zero.
    always_comb begin
        ReadData1 = regs_q[ReadReg1];
        if (ReadReg1 == 5'd0) begin
            ReadData1 = 32'h0;
        end else if (WriteEn_WB && (ReadReg1 == WriteAddr_WB)) begin
            ReadData1 = WriteData_WB;
        end
    end

    always_comb begin
        ReadData2 = regs_q[ReadReg2];
        if (ReadReg2 == 5'd0) begin
            ReadData2 = 32'h0;
        end else if (WriteEn_WB && (ReadReg2 == WriteAddr_WB)) begin
            ReadData2 = WriteData_WB;
        end
    end

    always_comb begin
        DbgData = (DbgReg == 5'd0) ? 32'h0 : regs_q[DbgReg];
    end

endmodule
